// File: rtl/note_pkg.sv
// Shared types and key-to-phase-step constants for the voice scheduler.
package note_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ATTACK,
    SUSTAIN,
    RELEASE
  } voice_state_t;

  localparam int unsigned SAMPLE_RATE = 48000;

  // Phase step for a 16-bit accumulator: round(f_Hz * 65536 / SAMPLE_RATE), f given in centi-Hz.
  function automatic int unsigned step_of(input int unsigned centi_hz);
    longint unsigned num;
    longint unsigned den;
    num = longint'(centi_hz) * 64'd65536 + 64'(50 * SAMPLE_RATE);
    den = 64'(100 * SAMPLE_RATE);
    return int'(num / den);
  endfunction

  localparam logic [7:0] KEY_A = 8'h61;
  localparam logic [7:0] KEY_S = 8'h73;
  localparam logic [7:0] KEY_D = 8'h64;
  localparam logic [7:0] KEY_F = 8'h66;
  localparam logic [7:0] KEY_G = 8'h67;
  localparam logic [7:0] KEY_H = 8'h68;
  localparam logic [7:0] KEY_J = 8'h6a;
  localparam logic [7:0] KEY_K = 8'h6b;

  localparam int unsigned STEP_C4 = step_of(26163);
  localparam int unsigned STEP_D4 = step_of(29366);
  localparam int unsigned STEP_E4 = step_of(32963);
  localparam int unsigned STEP_F4 = step_of(34923);
  localparam int unsigned STEP_G4 = step_of(39200);
  localparam int unsigned STEP_A4 = step_of(44000);
  localparam int unsigned STEP_B4 = step_of(49388);
  localparam int unsigned STEP_C5 = step_of(52325);

endpackage

// File: rtl/key_freq_rom.sv
// Combinational key code to phase-step lookup; hit=0 for unmapped codes.
module key_freq_rom
  import note_pkg::*;
#(
  parameter int unsigned FREQ_W = 16
) (
  input  logic [7:0]        code,
  output logic              hit,
  output logic [FREQ_W-1:0] step
);

  always_comb begin
    hit  = 1'b1;
    step = '0;
    case (code)
      KEY_A:   step = FREQ_W'(STEP_C4);
      KEY_S:   step = FREQ_W'(STEP_D4);
      KEY_D:   step = FREQ_W'(STEP_E4);
      KEY_F:   step = FREQ_W'(STEP_F4);
      KEY_G:   step = FREQ_W'(STEP_G4);
      KEY_H:   step = FREQ_W'(STEP_A4);
      KEY_J:   step = FREQ_W'(STEP_B4);
      KEY_K:   step = FREQ_W'(STEP_C5);
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/note_voice_sched.sv
// Voice controller: last-note-priority key stack, key-to-step mapping and
// attack/sustain/release gain envelope stepped once per audio sample.
module note_voice_sched
  import note_pkg::*;
#(
  parameter int unsigned SLOTS  = 4,
  parameter int unsigned FREQ_W = 16,
  parameter int unsigned RAMP   = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [7:0]        key_code,
  input  logic              key_release,
  input  logic              sample_tick,
  input  logic [3:0]        volume,
  output logic [FREQ_W-1:0] freq,
  output logic              voice_rst_n,
  output logic [7:0]        gain,
  output logic              active,
  output logic [3:0]        held_count,
  output logic              overflow
);

  localparam logic [8:0] RAMP9 = 9'(RAMP);

  voice_state_t      state_q, state_d;
  logic [7:0]        gain_q;
  logic [8:0]        gain9;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              rst_n_q, rst_n_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        stk_q [SLOTS];
  logic [7:0]        stk_d [SLOTS];
  logic [SLOTS-1:0]  vld_q, vld_d;

  logic              ev_hit, top_hit, ev_ok;
  logic [FREQ_W-1:0] ev_step, top_step;
  logic [7:0]        top_code;
  logic              held;
  int unsigned       held_idx, cnt;
  logic [8:0]        target;

  logic              shift_en, place_en, clear_en;
  int unsigned       shift_from, place_at, clear_at;

  key_freq_rom #(.FREQ_W(FREQ_W)) u_ev_rom (
    .code (key_code),
    .hit  (ev_hit),
    .step (ev_step)
  );

  key_freq_rom #(.FREQ_W(FREQ_W)) u_top_rom (
    .code (top_code),
    .hit  (top_hit),
    .step (top_step)
  );

  // Mapped keys always carry a non-zero step, so this only rejects unmapped codes.
  assign ev_ok = key_valid & ev_hit & (|ev_step);

  always_comb begin
    cnt      = 0;
    top_code = '0;
    held     = 1'b0;
    held_idx = 0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (vld_q[i]) begin
        cnt      = cnt + 1;
        top_code = stk_q[i];
        if (stk_q[i] == key_code) begin
          held     = 1'b1;
          held_idx = i;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gain9      = {1'b0, gain_q};
    freq_d     = freq_q;
    rst_n_d    = 1'b1;
    ovf_d      = 1'b0;
    stk_d      = stk_q;
    vld_d      = vld_q;
    target     = {5'b0, volume} * 9'd17;
    shift_en   = 1'b0;
    place_en   = 1'b0;
    clear_en   = 1'b0;
    shift_from = 0;
    place_at   = 0;
    clear_at   = 0;

    // Envelope and freq step see the pre-event stack and state.
    if (sample_tick) begin
      if (vld_q != '0 && top_hit) freq_d = top_step;
      case (state_q)
        ATTACK: begin
          gain9 = gain9 + RAMP9;
          if (gain9 >= target) begin
            gain9   = target;
            state_d = SUSTAIN;
          end
        end
        SUSTAIN: begin
          if (gain9 < target) begin
            gain9 = gain9 + RAMP9;
            if (gain9 > target) gain9 = target;
          end else if (gain9 - target > RAMP9) begin
            gain9 = gain9 - RAMP9;
          end else begin
            gain9 = target;
          end
        end
        RELEASE: begin
          if (gain9 <= RAMP9) begin
            gain9   = '0;
            state_d = IDLE;
            freq_d  = '0;
          end else begin
            gain9 = gain9 - RAMP9;
          end
        end
        default: ;
      endcase
    end

    if (ev_ok) begin
      if (!key_release) begin
        place_en = 1'b1;
        if (held) begin
          shift_en   = 1'b1;
          shift_from = held_idx;
          place_at   = cnt - 1;
        end else if (cnt >= SLOTS) begin
          shift_en   = 1'b1;
          shift_from = 0;
          place_at   = SLOTS - 1;
          ovf_d      = 1'b1;
        end else begin
          place_at = cnt;
        end
        if (state_q == IDLE) begin
          state_d = ATTACK;
          rst_n_d = 1'b0;
        end else if (state_q == RELEASE) begin
          state_d = ATTACK;
        end
      end else if (held) begin
        shift_en   = 1'b1;
        shift_from = held_idx;
        clear_en   = 1'b1;
        clear_at   = cnt - 1;
        if (cnt == 1 && (state_q == ATTACK || state_q == SUSTAIN)) state_d = RELEASE;
      end
    end

    // Compaction: entries above the removed/moved slot slide down by one.
    for (int unsigned i = 0; i < SLOTS - 1; i++) begin
      if (shift_en && i >= shift_from) stk_d[i] = stk_q[i+1];
    end
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (place_en && i == place_at) begin
        stk_d[i] = key_code;
        vld_d[i] = 1'b1;
      end
      if (clear_en && i == clear_at) vld_d[i] = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      gain_q  <= '0;
      freq_q  <= '0;
      rst_n_q <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= '0;
      stk_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      gain_q  <= (gain9 > 9'd255) ? 8'hff : gain9[7:0];
      freq_q  <= freq_d;
      rst_n_q <= rst_n_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      stk_q   <= stk_d;
    end
  end

  assign freq        = freq_q;
  assign voice_rst_n = rst_n_q;
  assign gain        = gain_q;
  assign active      = (state_q != IDLE);
  assign held_count  = 4'(cnt);
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_note_voice_sched.sv
// Directed bench for note_voice_sched: envelope, legato, overflow, event filtering, reset.
module tb_note_voice_sched;

  localparam logic [7:0] K_A = 8'h61;
  localparam logic [7:0] K_S = 8'h73;
  localparam logic [7:0] K_D = 8'h64;
  localparam logic [7:0] K_F = 8'h66;
  localparam logic [7:0] K_G = 8'h67;
  localparam logic [7:0] K_H = 8'h68;
  localparam logic [7:0] K_J = 8'h6a;
  localparam logic [7:0] K_K = 8'h6b;
  localparam logic [7:0] K_X = 8'h78;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        key_valid = 1'b0;
  logic [7:0]  key_code = '0;
  logic        key_release = 1'b0;
  logic        sample_tick = 1'b0;
  logic [3:0]  volume = 4'd15;
  logic [15:0] freq;
  logic        voice_rst_n;
  logic [7:0]  gain;
  logic        active;
  logic [3:0]  held_count;
  logic        overflow;

  int n_vec  = 0;
  int n_miss = 0;

  note_voice_sched #(.SLOTS(4), .FREQ_W(16), .RAMP(4)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_release (key_release),
    .sample_tick (sample_tick),
    .volume      (volume),
    .freq        (freq),
    .voice_rst_n (voice_rst_n),
    .gain        (gain),
    .active      (active),
    .held_count  (held_count),
    .overflow    (overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: inputs applied before the posedge, outputs sampled at the following negedge.
  task automatic cyc(input logic kv, input logic [7:0] code, input logic rel, input logic st);
    key_valid   = kv;
    key_code    = code;
    key_release = rel;
    sample_tick = st;
    @(negedge CLOCK_50);
    key_valid   = 1'b0;
    key_code    = '0;
    key_release = 1'b0;
    sample_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      idle(7);
    end
  endtask

  task automatic press(input logic [7:0] code);
    cyc(1'b1, code, 1'b0, 1'b0);
  endtask

  task automatic release_key(input logic [7:0] code);
    cyc(1'b1, code, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    check("rst_freq", 32'(freq), 0);
    check("rst_rstn", 32'(voice_rst_n), 0);
    check("rst_gain", 32'(gain), 0);
    check("rst_active", 32'(active), 0);
    check("rst_held", 32'(held_count), 0);
    check("rst_ovf", 32'(overflow), 0);
    reset = 1'b0;
    idle(1);
    check("rst_rstn_rel", 32'(voice_rst_n), 1);

    // 1: press/release 'h' at full volume
    press(K_H);
    check("t1_rstn_low", 32'(voice_rst_n), 0);
    check("t1_active", 32'(active), 1);
    check("t1_held", 32'(held_count), 1);
    check("t1_freq_pre", 32'(freq), 0);
    idle(1);
    check("t1_rstn_high", 32'(voice_rst_n), 1);
    ticks(1);
    check("t1_freq", 32'(freq), 601);
    check("t1_gain1", 32'(gain), 4);
    ticks(62);
    check("t1_gain63", 32'(gain), 252);
    ticks(1);
    check("t1_gain64", 32'(gain), 255);
    ticks(2);
    check("t1_sustain", 32'(gain), 255);
    release_key(K_H);
    check("t1_rel_held", 32'(held_count), 0);
    check("t1_rel_active", 32'(active), 1);
    ticks(1);
    check("t1_rel_gain1", 32'(gain), 251);
    check("t1_rel_freq", 32'(freq), 601);
    ticks(62);
    check("t1_rel_gain63", 32'(gain), 3);
    check("t1_rel_active63", 32'(active), 1);
    ticks(1);
    check("t1_idle_gain", 32'(gain), 0);
    check("t1_idle_active", 32'(active), 0);
    check("t1_idle_freq", 32'(freq), 0);

    // 2: legato a -> s -> a
    press(K_A);
    ticks(64);
    check("t2_gain", 32'(gain), 255);
    check("t2_freq_a", 32'(freq), 357);
    press(K_S);
    check("t2_no_restart", 32'(voice_rst_n), 1);
    check("t2_freq_hold", 32'(freq), 357);
    check("t2_held2", 32'(held_count), 2);
    ticks(1);
    check("t2_freq_s", 32'(freq), 401);
    check("t2_gain_s", 32'(gain), 255);
    release_key(K_S);
    check("t2_held1", 32'(held_count), 1);
    ticks(1);
    check("t2_freq_back", 32'(freq), 357);
    check("t2_active", 32'(active), 1);
    check("t2_gain_back", 32'(gain), 255);
    release_key(K_A);
    ticks(64);
    check("t2_idle", 32'(active), 0);

    // 3: overflow with SLOTS=4
    press(K_A);
    press(K_S);
    press(K_D);
    press(K_F);
    check("t3_held4", 32'(held_count), 4);
    check("t3_no_ovf", 32'(overflow), 0);
    press(K_G);
    check("t3_ovf", 32'(overflow), 1);
    check("t3_held_full", 32'(held_count), 4);
    idle(1);
    check("t3_ovf_pulse", 32'(overflow), 0);
    ticks(1);
    check("t3_freq_g", 32'(freq), 535);
    release_key(K_G);
    check("t3_held3", 32'(held_count), 3);
    ticks(1);
    check("t3_freq_f", 32'(freq), 477);
    release_key(K_F);
    ticks(1);
    check("t3_freq_d", 32'(freq), 450);
    release_key(K_D);
    ticks(1);
    check("t3_freq_s", 32'(freq), 401);
    check("t3_held1", 32'(held_count), 1);
    release_key(K_S);
    check("t3_empty", 32'(held_count), 0);
    ticks(1);
    check("t3_rel_freq", 32'(freq), 401);
    check("t3_rel_gain", 32'(gain), 12);
    check("t3_rel_active", 32'(active), 1);
    ticks(3);
    check("t3_idle_gain", 32'(gain), 0);
    check("t3_idle_active", 32'(active), 0);
    check("t3_idle_freq", 32'(freq), 0);

    // 4: event coincident with tick, then ignored events
    cyc(1'b1, K_K, 1'b0, 1'b1);
    check("t4_freq_pre", 32'(freq), 0);
    check("t4_gain_pre", 32'(gain), 0);
    check("t4_rstn", 32'(voice_rst_n), 0);
    check("t4_active", 32'(active), 1);
    check("t4_held", 32'(held_count), 1);
    idle(7);
    ticks(1);
    check("t4_freq_k", 32'(freq), 714);
    check("t4_gain_k", 32'(gain), 4);
    press(K_X);
    check("t4_x_held", 32'(held_count), 1);
    check("t4_x_ovf", 32'(overflow), 0);
    check("t4_x_freq", 32'(freq), 714);
    check("t4_x_gain", 32'(gain), 4);
    check("t4_x_rstn", 32'(voice_rst_n), 1);
    release_key(K_J);
    check("t4_j_held", 32'(held_count), 1);
    check("t4_j_active", 32'(active), 1);
    check("t4_j_freq", 32'(freq), 714);
    release_key(K_K);
    ticks(1);
    check("t4_end_gain", 32'(gain), 0);
    check("t4_end_active", 32'(active), 0);

    // 5: volume tracking in SUSTAIN, zero-volume attack
    press(K_A);
    ticks(64);
    check("t5_full", 32'(gain), 255);
    volume = 4'd8;
    ticks(29);
    check("t5_gain29", 32'(gain), 139);
    ticks(1);
    check("t5_gain30", 32'(gain), 136);
    ticks(2);
    check("t5_hold", 32'(gain), 136);
    release_key(K_A);
    ticks(34);
    check("t5_idle", 32'(active), 0);
    volume = 4'd0;
    press(K_D);
    ticks(3);
    check("t5_zero_gain", 32'(gain), 0);
    check("t5_zero_active", 32'(active), 1);
    check("t5_zero_freq", 32'(freq), 450);
    release_key(K_D);
    ticks(1);
    check("t5_zero_idle", 32'(active), 0);
    volume = 4'd15;

    // 6: reset mid-attack
    press(K_F);
    ticks(25);
    check("t6_gain100", 32'(gain), 100);
    reset = 1'b1;
    idle(1);
    check("t6_freq", 32'(freq), 0);
    check("t6_rstn", 32'(voice_rst_n), 0);
    check("t6_gain", 32'(gain), 0);
    check("t6_active", 32'(active), 0);
    check("t6_held", 32'(held_count), 0);
    check("t6_ovf", 32'(overflow), 0);
    reset = 1'b0;
    idle(1);
    check("t6_rstn_rel", 32'(voice_rst_n), 1);
    ticks(1);
    check("t6_freq_after", 32'(freq), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
